// File: rtl/xadc_drp_responder_pkg.sv
// Shared types and constants for the XADC DRP responder stand-in.
package xadc_drp_responder_pkg;

    localparam int XADC_DRP_ADDR_WIDTH = 7;
    localparam int XADC_DRP_DATA_WIDTH = 16;

    typedef logic [XADC_DRP_ADDR_WIDTH-1:0] xadc_drp_addr_t;
    typedef logic [XADC_DRP_DATA_WIDTH-1:0] xadc_drp_data_t;

    // Channel result registers and the writable configuration window
    localparam xadc_drp_addr_t XADC_DRP_ADDR_VOLTAGE_CHANNEL = 7'h03;
    localparam xadc_drp_addr_t XADC_DRP_ADDR_CURRENT_CHANNEL = 7'h10;
    localparam xadc_drp_addr_t XADC_DRP_ADDR_CONFIG_BASE     = 7'h40;

    localparam int XADC_DRP_RESPONDER_READ_LATENCY    = 4;
    localparam int XADC_DRP_RESPONDER_SEQUENCE_CYCLES = 104;
    localparam int XADC_DRP_RESPONDER_CONFIG_REGS     = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } xadc_drp_responder_state_t;

    // One conversion result: voltage in the upper half of the stream word
    typedef struct packed {
        xadc_drp_data_t voltage;
        xadc_drp_data_t current;
    } xadc_sample_pair_t;

    // True when addr falls inside the configuration register window
    function automatic logic in_config_range(input xadc_drp_addr_t addr, input int unsigned regs);
        int unsigned a;
        int unsigned base;
        a    = 32'(addr);
        base = 32'(XADC_DRP_ADDR_CONFIG_BASE);
        return (a >= base) && (a < base + regs);
    endfunction

endpackage

// File: rtl/xadc_drp_responder_if.sv
// DRP bus and AXI-Stream bundles used by the XADC responder.
interface xadc_drp_responder_if;
    import xadc_drp_responder_pkg::*;

    xadc_drp_addr_t xadc_daddr;
    logic           xadc_den;
    logic           xadc_dwe;
    xadc_drp_data_t xadc_di;
    logic           xadc_drdy;
    xadc_drp_data_t xadc_do;

    modport master (
        output xadc_daddr, xadc_den, xadc_dwe, xadc_di,
        input  xadc_drdy, xadc_do
    );

    modport slave (
        input  xadc_daddr, xadc_den, xadc_dwe, xadc_di,
        output xadc_drdy, xadc_do
    );
endinterface

interface axis_interface #(
    parameter int DATA_WIDTH = 32
);
    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic                    tlast;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic [7:0]              tid;
    logic [3:0]              tdest;
    logic                    tuser;

    modport Source (
        output tvalid, tdata, tlast, tkeep, tid, tdest, tuser,
        input  tready
    );

    modport Sink (
        input  tvalid, tdata, tlast, tkeep, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/xadc_drp_responder_eos_sequencer.sv
// Free-running conversion-sequence counter producing a one-cycle EOS pulse
// each time the count wraps back to zero.
module xadc_eos_sequencer #(
    parameter int SEQUENCE_CYCLES = 104
) (
    input  logic xadc_dclk,
    input  logic xadc_reset,
    output logic eos_o
);

    localparam int              CNT_W = $clog2(SEQUENCE_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SEQUENCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             eos_q, eos_d;

    // Next count; the pulse is registered so it lines up with the wrap to 0
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        eos_d = 1'b0;
        if (cnt_q == LAST) begin
            cnt_d = '0;
            eos_d = 1'b1;
        end
    end

    // Counter and pulse registers
    always_ff @(posedge xadc_dclk or posedge xadc_reset) begin
        if (xadc_reset) begin
            cnt_q <= '0;
            eos_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            eos_q <= eos_d;
        end
    end

    assign eos_o = eos_q;

endmodule

// File: rtl/xadc_drp_responder.sv
// XADC DRP slave stand-in: fixed-latency DRP responder, config scratch
// registers, and channel registers refreshed from an AXIS stimulus slot at
// every end-of-sequence.
module xadc_drp_responder
    import xadc_drp_responder_pkg::*;
#(
    parameter int READ_LATENCY    = XADC_DRP_RESPONDER_READ_LATENCY,
    parameter int SEQUENCE_CYCLES = XADC_DRP_RESPONDER_SEQUENCE_CYCLES,
    parameter int CONFIG_REGS     = XADC_DRP_RESPONDER_CONFIG_REGS
) (
    input  logic                 xadc_dclk,
    input  logic                 xadc_reset,
    xadc_drp_responder_if.slave  drp,
    output logic                 xadc_eos,
    axis_interface.Sink          stimulus_stream,
    output logic [15:0]          underrun_count,
    output logic                 protocol_error
);

    localparam logic [3:0] LAT_LOAD = 4'(READ_LATENCY - 1);

    // ---------------- sequencer ----------------
    logic eos;

    xadc_eos_sequencer #(
        .SEQUENCE_CYCLES(SEQUENCE_CYCLES)
    ) u_eos_sequencer (
        .xadc_dclk (xadc_dclk),
        .xadc_reset(xadc_reset),
        .eos_o     (eos)
    );

    assign xadc_eos = eos;

    // ---------------- DRP FSM ----------------
    xadc_drp_responder_state_t state_q, state_d;
    logic [3:0]        lat_q, lat_d;
    xadc_drp_addr_t    addr_q;
    logic              dwe_q;
    xadc_drp_data_t    di_q;
    xadc_drp_data_t    snap_q;
    logic              perr_q;
    logic              drdy;
    logic              accept;
    logic              collide;

    // Next state, latency countdown and request acceptance; a request on the
    // completion cycle is taken as a fresh back-to-back transaction
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        drdy    = 1'b0;
        accept  = 1'b0;
        collide = 1'b0;
        case (state_q)
            IDLE: begin
                if (drp.xadc_den) accept = 1'b1;
            end
            BUSY: begin
                if (lat_q == 4'd0) begin
                    drdy    = 1'b1;
                    state_d = IDLE;
                    if (drp.xadc_den) accept = 1'b1;
                end else begin
                    lat_d = lat_q - 4'd1;
                    if (drp.xadc_den) collide = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            state_d = BUSY;
            lat_d   = LAT_LOAD;
        end
    end

    // ---------------- config register file ----------------
    xadc_drp_data_t    cfg_q [CONFIG_REGS];
    logic              cfg_we;
    logic [6:0]        wr_offset;
    logic [6:0]        rd_offset;
    logic [CONFIG_REGS-1:0] cfg_sel;
    xadc_drp_data_t    rd_data;

    assign cfg_we    = drdy && dwe_q && in_config_range(addr_q, CONFIG_REGS);
    assign wr_offset = addr_q - XADC_DRP_ADDR_CONFIG_BASE;
    assign rd_offset = drp.xadc_daddr - XADC_DRP_ADDR_CONFIG_BASE;

    for (genvar gi = 0; gi < CONFIG_REGS; gi++) begin : g_cfg_sel
        assign cfg_sel[gi] = cfg_we && (wr_offset == 7'(gi));
    end

    // Config registers; a write lands at the end of its drdy cycle
    always_ff @(posedge xadc_dclk or posedge xadc_reset) begin
        if (xadc_reset) begin
            for (int i = 0; i < CONFIG_REGS; i++) cfg_q[i] <= '0;
        end else begin
            for (int i = 0; i < CONFIG_REGS; i++) begin
                if (cfg_sel[i]) cfg_q[i] <= di_q;
            end
        end
    end

    // ---------------- stimulus slot and channel registers ----------------
    xadc_sample_pair_t ch_q, ch_d;
    xadc_sample_pair_t slot_data_q, slot_data_d;
    logic              slot_full_q, slot_full_d;
    logic              tready_q, tready_d;
    logic [15:0]       underrun_q, underrun_d;
    logic              handshake;

    assign handshake = stimulus_stream.tvalid && tready_q;

    // EOS consumes the slot that was full before this cycle; a word handshaken
    // on the EOS cycle only refills the slot for the following sequence
    always_comb begin
        ch_d        = ch_q;
        slot_data_d = slot_data_q;
        slot_full_d = slot_full_q;
        underrun_d  = underrun_q;
        if (eos) begin
            if (slot_full_q) begin
                ch_d        = slot_data_q;
                slot_full_d = 1'b0;
            end else if (underrun_q != 16'hFFFF) begin
                underrun_d = underrun_q + 16'd1;
            end
        end
        if (handshake) begin
            slot_data_d = xadc_sample_pair_t'(stimulus_stream.tdata);
            slot_full_d = 1'b1;
        end
        tready_d = !slot_full_d;
    end

    // Read data for a request accepted this cycle; channel values are the
    // pre-EOS ones, and a config write completing now is forwarded
    always_comb begin
        rd_data = '0;
        if (drp.xadc_daddr == XADC_DRP_ADDR_VOLTAGE_CHANNEL) begin
            rd_data = ch_q.voltage;
        end else if (drp.xadc_daddr == XADC_DRP_ADDR_CURRENT_CHANNEL) begin
            rd_data = ch_q.current;
        end else if (in_config_range(drp.xadc_daddr, CONFIG_REGS)) begin
            for (int i = 0; i < CONFIG_REGS; i++) begin
                if (rd_offset == 7'(i)) rd_data = cfg_q[i];
            end
            if (cfg_we && (wr_offset == rd_offset)) rd_data = di_q;
        end
    end

    // DRP transaction, stimulus and status registers
    always_ff @(posedge xadc_dclk or posedge xadc_reset) begin
        if (xadc_reset) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            addr_q      <= '0;
            dwe_q       <= 1'b0;
            di_q        <= '0;
            snap_q      <= '0;
            perr_q      <= 1'b0;
            ch_q        <= '0;
            slot_data_q <= '0;
            slot_full_q <= 1'b0;
            tready_q    <= 1'b0;
            underrun_q  <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            perr_q      <= perr_q | collide;
            ch_q        <= ch_d;
            slot_data_q <= slot_data_d;
            slot_full_q <= slot_full_d;
            tready_q    <= tready_d;
            underrun_q  <= underrun_d;
            if (accept) begin
                addr_q <= drp.xadc_daddr;
                dwe_q  <= drp.xadc_dwe;
                di_q   <= drp.xadc_di;
                snap_q <= rd_data;
            end
        end
    end

    assign drp.xadc_drdy          = drdy;
    assign drp.xadc_do            = drdy ? snap_q : '0;
    assign stimulus_stream.tready = tready_q;
    assign underrun_count         = underrun_q;
    assign protocol_error         = perr_q;

    // Sideband stream fields carry no meaning for this block
    logic unused_axis_sideband;
    assign unused_axis_sideband = ^{stimulus_stream.tlast, stimulus_stream.tkeep,
                                    stimulus_stream.tid, stimulus_stream.tdest,
                                    stimulus_stream.tuser};

endmodule

// File: tb/tb_xadc_drp_responder.sv
// Testbench for xadc_drp_responder: directed scenarios plus a randomized run,
// all checked cycle by cycle against a transaction-level reference model.
module tb_xadc_drp_responder;
    import xadc_drp_responder_pkg::*;

    localparam int LAT  = 4;
    localparam int SEQ  = 16;
    localparam int NCFG = 32;

    localparam logic [6:0] A_V = XADC_DRP_ADDR_VOLTAGE_CHANNEL;
    localparam logic [6:0] A_C = XADC_DRP_ADDR_CURRENT_CHANNEL;
    localparam logic [6:0] A_B = XADC_DRP_ADDR_CONFIG_BASE;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        eos;
    logic [15:0] underrun;
    logic        perr;

    always #5 clk = ~clk;

    xadc_drp_responder_if drp ();
    axis_interface #(.DATA_WIDTH(32)) axis ();

    xadc_drp_responder #(
        .READ_LATENCY   (LAT),
        .SEQUENCE_CYCLES(SEQ),
        .CONFIG_REGS    (NCFG)
    ) dut (
        .xadc_dclk      (clk),
        .xadc_reset     (rst),
        .drp            (drp),
        .xadc_eos       (eos),
        .stimulus_stream(axis),
        .underrun_count (underrun),
        .protocol_error (perr)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [15:0] data;
        bit          wr;
        logic [6:0]  addr;
        logic [15:0] wdata;
    } txn_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic [15:0] m_v, m_c;
    logic [15:0] m_cfg [NCFG];
    bit          m_full;
    logic [31:0] m_slot;
    int          m_under;
    bit          m_perr;
    txn_t        pend[$];
    int          drdy_seen;
    logic [15:0] last_do;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] m_read(input logic [6:0] a);
        int idx;
        idx = int'(a) - int'(A_B);
        if (a == A_V) return m_v;
        if (a == A_C) return m_c;
        if (idx >= 0 && idx < NCFG) return m_cfg[idx];
        return 16'h0000;
    endfunction

    task automatic model_reset();
        m_v = '0; m_c = '0; m_full = 0; m_slot = '0; m_under = 0; m_perr = 0;
        for (int i = 0; i < NCFG; i++) m_cfg[i] = '0;
        pend.delete();
        cyc = 0;
    endtask

    // Advance the model across the clock edge that closes cycle cyc
    task automatic model_step();
        bit   eos_now;
        bit   tready_now;
        bit   completing;
        bit   busy;
        bit   full_pre;
        int   idx;
        txn_t t;
        eos_now    = (cyc > 0) && (cyc % SEQ == 0);
        tready_now = (cyc > 0) && !m_full;
        completing = (pend.size() > 0) && (pend[0].due == cyc);
        busy       = (pend.size() > 0) && !completing;
        full_pre   = m_full;
        if (completing) begin
            t = pend.pop_front();
            idx = int'(t.addr) - int'(A_B);
            if (t.wr && idx >= 0 && idx < NCFG) m_cfg[idx] = t.wdata;
        end
        if (drp.xadc_den) begin
            if (busy) begin
                m_perr = 1;
            end else begin
                t.due   = cyc + LAT;
                t.data  = m_read(drp.xadc_daddr);
                t.wr    = drp.xadc_dwe;
                t.addr  = drp.xadc_daddr;
                t.wdata = drp.xadc_di;
                pend.push_back(t);
            end
        end
        if (eos_now) begin
            if (full_pre) begin
                m_v    = m_slot[31:16];
                m_c    = m_slot[15:0];
                m_full = 0;
            end else if (m_under < 65535) begin
                m_under++;
            end
        end
        if (axis.tvalid && tready_now) begin
            m_slot = axis.tdata;
            m_full = 1;
        end
        cyc++;
    endtask

    task automatic compare();
        bit          exp_drdy;
        logic [15:0] exp_do;
        exp_drdy = (pend.size() > 0) && (pend[0].due == cyc);
        exp_do   = exp_drdy ? pend[0].data : 16'h0000;
        check("eos", eos, (cyc % SEQ == 0));
        check("drdy", drp.xadc_drdy, exp_drdy);
        check("do", drp.xadc_do, exp_do);
        check("tready", axis.tready, !m_full);
        check("underrun", underrun, m_under);
        check("perr", perr, m_perr);
        if (drp.xadc_drdy) begin
            drdy_seen++;
            last_do = drp.xadc_do;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        compare();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_cyc(input int k);
        int n;
        n = 0;
        while (cyc < k && n < 1000) begin tick(); n++; end
        check("wait_cyc", cyc, k);
    endtask

    task automatic do_reset();
        drp.xadc_den = 0; drp.xadc_dwe = 0; axis.tvalid = 0;
        rst = 1;
        #1;
        check("rst_drdy", drp.xadc_drdy, 0);
        check("rst_do", drp.xadc_do, 0);
        check("rst_eos", eos, 0);
        check("rst_tready", axis.tready, 0);
        check("rst_underrun", underrun, 0);
        check("rst_perr", perr, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic drp_xfer(input bit wr, input logic [6:0] a, input logic [15:0] wd,
                            output logic [15:0] rd, output int lat);
        drp.xadc_den = 1; drp.xadc_dwe = wr; drp.xadc_daddr = a; drp.xadc_di = wd;
        tick();
        drp.xadc_den = 0; drp.xadc_dwe = 0;
        lat = 1;
        while (!drp.xadc_drdy && lat < 20) begin tick(); lat++; end
        check("drdy_timeout", drp.xadc_drdy, 1);
        rd = drp.xadc_do;
        $display("[TB] drp %s addr=0x%02h wdata=0x%04h do=0x%04h latency=%0d",
                 wr ? "wr" : "rd", a, wd, rd, lat);
    endtask

    task automatic push(input logic [31:0] d);
        int n;
        n = 0;
        axis.tvalid = 1; axis.tdata = d;
        while (!axis.tready && n < 200) begin tick(); n++; end
        check("push_ready", axis.tready, 1);
        tick();
        axis.tvalid = 0;
        $display("[TB] axis push 0x%08h", d);
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        logic [15:0] rd;
        int          lat;
        int          r;

        drp.xadc_den = 0; drp.xadc_dwe = 0; drp.xadc_daddr = '0; drp.xadc_di = '0;
        axis.tvalid = 0; axis.tdata = '0; axis.tlast = 0; axis.tkeep = '0;
        axis.tid = '0; axis.tdest = '0; axis.tuser = 0;
        drdy_seen = 0; last_do = '0;

        @(posedge clk); #1;
        do_reset();

        // 1: EOS cadence and underrun with no stimulus
        idle(49);
        check("t1_underrun", underrun, 3);

        // 2: stimulus word published at first EOS
        do_reset();
        push(32'h1234_ABCD);
        wait_cyc(17);
        drp_xfer(0, A_V, 16'h0, rd, lat);
        check("t2_volt", rd, 16'h1234); check("t2_lat_v", lat, LAT);
        drp_xfer(0, A_C, 16'h0, rd, lat);
        check("t2_curr", rd, 16'hABCD); check("t2_lat_c", lat, LAT);

        // 3: config write/read, read-only channel, unmapped, window edges
        drp_xfer(1, A_B + 7'd3, 16'hBEEF, rd, lat);
        drp_xfer(0, A_B + 7'd3, 16'h0, rd, lat);
        check("t3_cfg3", rd, 16'hBEEF);
        drp_xfer(1, A_V, 16'hDEAD, rd, lat);
        check("t3_wr_lat", lat, LAT);
        drp_xfer(0, A_V, 16'h0, rd, lat);
        check("t3_volt_ro", rd, 16'h1234);
        drp_xfer(0, 7'h7F, 16'h0, rd, lat);
        check("t3_unmapped", rd, 16'h0000);
        drp_xfer(1, A_B + 7'd31, 16'hC0DE, rd, lat);
        drp_xfer(0, A_B + 7'd31, 16'h0, rd, lat);
        check("t3_cfg_last", rd, 16'hC0DE);
        drp_xfer(1, A_B + 7'd32, 16'h5A5A, rd, lat);
        drp_xfer(0, A_B + 7'd32, 16'h0, rd, lat);
        check("t3_past_window", rd, 16'h0000);
        drp_xfer(1, A_B + 7'd5, 16'h4321, rd, lat);
        drp_xfer(0, A_B + 7'd5, 16'h0, rd, lat);
        check("t3_b2b_wr_rd", rd, 16'h4321);
        tick();

        // 4: den while busy
        check("t4_perr_clear", perr, 0);
        drdy_seen = 0;
        drp.xadc_den = 1; drp.xadc_dwe = 0; drp.xadc_daddr = A_V; tick();
        drp.xadc_den = 0; tick();
        drp.xadc_den = 1; drp.xadc_daddr = A_C; tick();
        drp.xadc_den = 0; idle(8);
        check("t4_one_drdy", drdy_seen, 1);
        check("t4_first_data", last_do, 16'h1234);
        check("t4_perr", perr, 1);
        // back-to-back on the drdy cycle
        do_reset();
        drdy_seen = 0;
        drp_xfer(0, A_V, 16'h0, rd, lat);
        check("t4_b2b_lat1", lat, LAT);
        drp_xfer(0, A_C, 16'h0, rd, lat);
        check("t4_b2b_lat2", lat, LAT);
        tick();
        check("t4_b2b_drdys", drdy_seen, 2);
        check("t4_b2b_perr", perr, 0);

        // 5: read on the EOS cycle, handshake on the EOS cycle
        do_reset();
        push(32'h1111_2222);
        wait_cyc(18);
        push(32'h5555_6666);
        wait_cyc(32);
        check("t5_eos_now", eos, 1);
        drp_xfer(0, A_V, 16'h0, rd, lat);
        check("t5_old_value", rd, 16'h1111);
        drp_xfer(0, A_V, 16'h0, rd, lat);
        check("t5_new_value", rd, 16'h5555);
        wait_cyc(48);
        axis.tvalid = 1; axis.tdata = 32'h7777_8888;
        check("t5_tready_on_eos", axis.tready, 1);
        tick();
        axis.tvalid = 0;
        drp_xfer(0, A_V, 16'h0, rd, lat);
        check("t5_not_applied", rd, 16'h5555);
        wait_cyc(65);
        drp_xfer(0, A_V, 16'h0, rd, lat);
        check("t5_applied_next", rd, 16'h7777);

        // 6: reset while busy with slot full
        do_reset();
        push(32'h9999_AAAA);
        drp.xadc_den = 1; drp.xadc_daddr = A_V; tick();
        drp.xadc_den = 0; tick();
        do_reset();
        drdy_seen = 0;
        idle(LAT + 3);
        check("t6_no_drdy", drdy_seen, 0);
        check("t6_tready", axis.tready, 1);
        check("t6_underrun", underrun, 0);
        wait_cyc(17);
        drp_xfer(0, A_V, 16'h0, rd, lat);
        check("t6_slot_dropped", rd, 16'h0000);

        // underrun saturation
        wait_cyc(35);
        force dut.underrun_q = 16'hFFFE;
        m_under = 65534;
        tick();
        release dut.underrun_q;
        wait_cyc(81);
        check("sat_ffff", underrun, 16'hFFFF);

        // randomized traffic
        do_reset();
        for (int it = 0; it < 1500; it++) begin
            r = int'($urandom_range(0, 4));
            case (r)
                0: drp.xadc_daddr = A_V;
                1: drp.xadc_daddr = A_C;
                2: drp.xadc_daddr = A_B + 7'($urandom_range(0, NCFG - 1));
                3: drp.xadc_daddr = A_B + 7'($urandom_range(NCFG - 2, NCFG + 1));
                default: drp.xadc_daddr = 7'($urandom);
            endcase
            drp.xadc_den = ($urandom_range(0, 3) == 0);
            drp.xadc_dwe = 1'($urandom);
            drp.xadc_di  = 16'($urandom);
            axis.tvalid  = ($urandom_range(0, 2) == 0);
            axis.tdata   = $urandom;
            axis.tlast   = 1'($urandom);
            axis.tkeep   = 4'($urandom);
            axis.tid     = 8'($urandom);
            axis.tdest   = 4'($urandom);
            axis.tuser   = 1'($urandom);
            tick();
            if ($urandom_range(0, 499) == 0) do_reset();
        end
        drp.xadc_den = 0; axis.tvalid = 0;
        idle(LAT + 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
